hf_mac_sched: RTL and testbench

HF_MAC_SCHED -- requirements
Module: hf_mac_sched

---
 rtl/hf_mac_sched_pkg.sv | 38 +++
 rtl/hf_mac_sched_tap_seq.sv | 35 +++
 rtl/hf_mac_sched.sv | 158 +++++++++++++++
 tb/tb_hf_mac_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hf_mac_sched_pkg.sv
// Shared definitions for the Hilbert-filter MAC scheduler: FSM state
// encoding, default filter order, 1Q10 coefficient constants, port widths
// and the enabled-channel search helper.
package hf_pkg;

    localparam int DEF_ORDER = 8;

    localparam int MASK_W = 4;
    localparam int CH_W   = 2;
    localparam int TAP_W  = 5;
    localparam int COEF_W = 4;
    localparam int STEP_W = 4;

    // Non-zero odd-tap coefficient magnitudes, 1Q10
    localparam logic [10:0] HA = 11'd245;
    localparam logic [10:0] HB = 11'd641;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Lowest enabled channel at index >= from; MSB of the result set means none.
    function automatic logic [CH_W:0] next_ch(input logic [MASK_W-1:0] mask,
                                              input logic [CH_W:0]     from);
        logic [CH_W:0] r_found;
        r_found = 3'd4;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i] && ((CH_W + 1)'(i) >= from)) begin
                r_found = (CH_W + 1)'(i);
            end
        end
        return r_found;
    endfunction

endpackage

// File: rtl/hf_mac_sched_tap_seq.sv
// Step decoder: maps a MAC step to the odd tap address, the folded
// coefficient index and the accumulate direction (subtract in first half).
module hf_tap_seq
    import hf_pkg::*;
#(
    parameter int NSTEP = DEF_ORDER / 2
) (
    input  logic [STEP_W-1:0] i_step,
    output logic [TAP_W-1:0]  o_tap_addr,
    output logic [COEF_W-1:0] o_coef_idx,
    output logic              o_sub
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);
    localparam logic [STEP_W-1:0] HALF_STEP = STEP_W'(NSTEP / 2);

    logic [STEP_W-1:0] w_mirror;

    // Tap address 2*step+1, coefficient index min(step, mirror), sign select
    always_comb begin
        w_mirror   = LAST_STEP - i_step;
        o_tap_addr = {i_step, 1'b1};
        if (i_step <= w_mirror) begin
            o_coef_idx = i_step;
        end else begin
            o_coef_idx = w_mirror;
        end
        if (i_step < HALF_STEP) begin
            o_sub = 1'b1;
        end else begin
            o_sub = 1'b0;
        end
    end

endmodule

// File: rtl/hf_mac_sched.sv
// Hilbert-filter shared-MAC scheduler. Walks each enabled channel through a
// one-cycle accumulator clear followed by NSTEP MAC steps, then pulses done.
// Optional feature macro: HF_SCHED_MASK_EN -- when defined, ch_mask selects
// the channels processed; otherwise all four channels are always processed.
module hf_mac_sched
    import hf_pkg::*;
#(
    parameter int ORDER = DEF_ORDER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MASK_W-1:0] ch_mask,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [CH_W-1:0]   ch_sel,
    output logic [TAP_W-1:0]  tap_addr,
    output logic [COEF_W-1:0] coef_idx,
    output logic              sub,
    output logic              acc_clr,
    output logic              acc_en
);

    localparam int                NSTEP     = ORDER / 2;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [MASK_W-1:0]   r_mask;
    logic [CH_W-1:0]     r_ch;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                r_acc_clr;
    logic                r_acc_en;

    logic [MASK_W-1:0]   w_mask;
    logic [CH_W:0]       w_first;
    logic [CH_W:0]       w_next;
    logic                w_active;
    logic [TAP_W-1:0]    w_tap;
    logic [COEF_W-1:0]   w_coef;
    logic                w_sub;

`ifdef HF_SCHED_MASK_EN
    assign w_mask = ch_mask;
`else
    // All channels forced on; ch_mask has no effect in this build
    assign w_mask = ch_mask | 4'b1111;
`endif

    assign w_first  = next_ch(w_mask, 3'd0);
    assign w_next   = next_ch(r_mask, {1'b0, r_ch} + 3'd1);
    assign w_active = (r_state == ST_CLR) || (r_state == ST_RUN);

    hf_tap_seq #(
        .NSTEP      (NSTEP)
    ) u_tap_seq (
        .i_step     (r_step),
        .o_tap_addr (w_tap),
        .o_coef_idx (w_coef),
        .o_sub      (w_sub)
    );

    // Sequencing FSM with registered status and accumulator controls
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_step    <= 4'd0;
            r_mask    <= 4'd0;
            r_ch      <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_acc_clr <= 1'b0;
            r_acc_en  <= 1'b0;
        end else begin
            if (start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_done    <= 1'b0;
                    r_acc_clr <= 1'b0;
                    r_acc_en  <= 1'b0;
                    r_step    <= 4'd0;
                    r_ch      <= 2'd0;
                    if (start) begin
                        r_overrun <= 1'b0;
                        r_mask    <= w_mask;
                        r_busy    <= 1'b1;
                        if (w_first[CH_W]) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_CLR;
                            r_ch      <= w_first[CH_W-1:0];
                            r_acc_clr <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_CLR: begin
                    r_state   <= ST_RUN;
                    r_step    <= 4'd0;
                    r_acc_clr <= 1'b0;
                    r_acc_en  <= 1'b1;
                end
                ST_RUN: begin
                    if (r_step == LAST_STEP) begin
                        r_step   <= 4'd0;
                        r_acc_en <= 1'b0;
                        if (w_next[CH_W]) begin
                            r_state <= ST_DONE;
                            r_ch    <= 2'd0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_CLR;
                            r_ch      <= w_next[CH_W-1:0];
                            r_acc_clr <= 1'b1;
                        end
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_step  <= 4'd0;
                    r_ch    <= 2'd0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_step    <= 4'd0;
                    r_ch      <= 2'd0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_acc_clr <= 1'b0;
                    r_acc_en  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign acc_clr  = r_acc_clr;
    assign acc_en   = r_acc_en;
    assign ch_sel   = r_ch;
    assign tap_addr = w_active ? w_tap  : 5'd0;
    assign coef_idx = w_active ? w_coef : 4'd0;
    assign sub      = w_active ? w_sub  : 1'b0;

endmodule

// File: tb/tb_hf_mac_sched.sv
// Directed bench for hf_mac_sched with ORDER=8 (NSTEP=4).
module tb_hf_mac_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] ch_mask;
    logic       busy, done, overrun, sub, acc_clr, acc_en;
    logic [1:0] ch_sel;
    logic [4:0] tap_addr;
    logic [3:0] coef_idx;

    hf_mac_sched #(.ORDER(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .ch_mask  (ch_mask),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .ch_sel   (ch_sel),
        .tap_addr (tap_addr),
        .coef_idx (coef_idx),
        .sub      (sub),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en)
    );

    always #5 clock = ~clock;

`ifdef HF_SCHED_MASK_EN
    localparam int  E_B  = 2;
    localparam int  E_C  = 0;
    localparam logic [7:0] SEQ_B = 8'h02;
`else
    localparam int  E_B  = 4;
    localparam int  E_C  = 4;
    localparam logic [7:0] SEQ_B = 8'h1B;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int          done_cyc, busy_cnt, busy_first, busy_last, en_cnt, clr_cnt;
    int          zero_viol, done_cnt, ov_first;
    logic [31:0] clr_pos;
    logic [7:0]  ch_seq;
    logic [9:0]  tr [4];
    logic [16:0] snap;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {busy, done, overrun, ch_sel, tap_addr, coef_idx, sub, acc_clr, acc_en};
    endfunction

    function automatic int exp_clr(input int e);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < e; i++) v[1 + 5 * i] = 1'b1;
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start in cycle 0; optional extra start / reset in cycle dup_at / rst_at.
    task automatic run_seq(input logic [3:0] m, input int dup_at, input int rst_at);
        done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
        en_cnt = 0; clr_cnt = 0; zero_viol = 0; done_cnt = 0; ov_first = -1;
        clr_pos = 32'd0; ch_seq = 8'd0; snap = 17'h1FFFF;
        for (int i = 0; i < 4; i++) tr[i] = 10'd0;
        ch_mask = m;
        start   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = (k == dup_at);
            reset = (k == rst_at);
            if (k == 1) ov_first = int'(overrun);
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (acc_en) begin
                if (en_cnt < 4) tr[en_cnt] = {tap_addr, coef_idx, sub};
                en_cnt++;
            end
            if (acc_clr) begin
                clr_cnt++;
                if (k < 32) clr_pos[k] = 1'b1;
                ch_seq = {ch_seq[5:0], ch_sel};
            end
            if (!acc_clr && !acc_en && ({ch_sel, tap_addr, coef_idx, sub} != 12'd0)) zero_viol++;
            if (acc_clr && acc_en) zero_viol++;
            if (k == rst_at + 1) snap = outs();
            if (done) begin
                done_cnt++;
                done_cyc = k;
                break;
            end
        end
        tick();
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ch_mask = 4'd0;
        tick(); tick(); tick();
        chk("reset_outputs", int'(outs()), 0);
        reset = 1'b0;
        tick();

        // Full mask: timing, counts, channel order, ch0 tap sequence
        run_seq(4'hF, -1, -1);
        chk("A_done_cycle", done_cyc, 21);
        chk("A_busy_cnt", busy_cnt, 21);
        chk("A_busy_first", busy_first, 1);
        chk("A_busy_last", busy_last, 21);
        chk("A_acc_en_cnt", en_cnt, 16);
        chk("A_acc_clr_cnt", clr_cnt, 4);
        chk("A_acc_clr_pos", int'(clr_pos), exp_clr(4));
        chk("A_ch_seq", int'(ch_seq), 32'h1B);
        chk("A_idle_zero", zero_viol, 0);
        chk("A_tap0", int'(tr[0]), int'({5'd1, 4'd0, 1'b1}));
        chk("A_tap1", int'(tr[1]), int'({5'd3, 4'd1, 1'b1}));
        chk("A_tap2", int'(tr[2]), int'({5'd5, 4'd1, 1'b0}));
        chk("A_tap3", int'(tr[3]), int'({5'd7, 4'd0, 1'b0}));
        chk("A_overrun", int'(overrun), 0);
        chk("A_idle_busy", int'(busy), 0);

        // Mask 0101
        run_seq(4'h5, -1, -1);
        chk("B_done_cycle", done_cyc, 1 + E_B * 5);
        chk("B_acc_en_cnt", en_cnt, E_B * 4);
        chk("B_acc_clr_pos", int'(clr_pos), exp_clr(E_B));
        chk("B_ch_seq", int'(ch_seq), int'(SEQ_B));
        chk("B_idle_zero", zero_viol, 0);

        // Mask 0000
        run_seq(4'h0, -1, -1);
        chk("C_done_cycle", done_cyc, 1 + E_C * 5);
        chk("C_busy_cnt", busy_cnt, 1 + E_C * 5);
        chk("C_acc_en_cnt", en_cnt, E_C * 4);
        chk("C_acc_clr_cnt", clr_cnt, E_C);

        // Extra start mid-sequence
        run_seq(4'hF, 5, -1);
        chk("D_done_cycle", done_cyc, 21);
        chk("D_acc_en_cnt", en_cnt, 16);
        chk("D_acc_clr_pos", int'(clr_pos), exp_clr(4));
        chk("D_overrun_set", int'(overrun), 1);

        // Accepted start clears overrun; start in DONE cycle sets it
        run_seq(4'hF, 21, -1);
        chk("E_overrun_clr", ov_first, 0);
        chk("E_done_cycle", done_cyc, 21);
        chk("E_overrun_done", int'(overrun), 1);

        // Reset at cycle 8 together with a start: abort, reset wins
        run_seq(4'hF, 8, 8);
        chk("F_reset_snap", int'(snap), 0);
        chk("F_no_done", done_cnt, 0);
        chk("F_overrun", int'(overrun), 0);

        // Normal sequence after reset abort
        run_seq(4'hF, -1, -1);
        chk("G_done_cycle", done_cyc, 21);
        chk("G_acc_en_cnt", en_cnt, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
